axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_pkg.sv | 23 ++
 rtl/axil_cmd_master_if.sv | 50 +++++
 rtl/axil_timeout_ctr.sv | 35 +++
 rtl/axil_cmd_master.sv | 124 ++++++++++++
 tb/tb_axil_cmd_master.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/axil_cmd_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axil_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // States in which the block is waiting on the AXI-Lite slave.
    function automatic logic is_axi_wait(input state_t s);
        return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// Command/response port plus AXI4-Lite master port of axil_cmd_master.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel.
interface axil_cmd_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_awaddr;
    logic        m_wvalid;
    logic        m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  m_bresp;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp,
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
        output m_arvalid, m_araddr, m_rready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
        input  m_arvalid, m_araddr, m_rready
    );
endinterface

// File: rtl/axil_timeout_ctr.sv
// Saturating AXI-wait counter with a sticky timeout flag (TIMEOUT_CYCLES=0 disables it).
// Latency: flag rises on the edge at which the count reaches TIMEOUT_CYCLES.
// Backpressure: none; purely observes the enable.
module axil_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_main_a0,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout_err
);
    // Width always holds TIMEOUT_CYCLES+1, so saturation never hides the match.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clr) begin
                cnt_q <= '0;
            end else if (en && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if ((TIMEOUT_CYCLES != 0) && en && !clr && (cnt_q == CNT_LAST)) begin
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding command to AXI4-Lite master bridge with sticky wait timeout.
// Latency: AXI valids 1 cycle after accept; rsp_valid no earlier than 3 cycles after accept.
// Backpressure: req_ready only when idle; rsp held until rsp_ready, AXI valids held until handshake.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n,
    axil_cmd_master_if.master   bus,
    output logic                timeout_err
);
    logic [1:0]  rst_sync_q;
    logic        rst_n;
    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  resp_q;
    logic        aw_done_q, w_done_q;
    logic        accept, aw_hs, w_hs;

    // Reset asserts immediately, releases two clocks after rst_main_n rises.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign aw_hs  = bus.m_awvalid && bus.m_awready;
    assign w_hs   = bus.m_wvalid && bus.m_wready;

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.m_awvalid = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_bready  = 1'b0;
        bus.m_arvalid = 1'b0;
        bus.m_rready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = bus.req_write ? ST_WR : ST_RD_ADDR;
            end
            ST_WR: begin
                bus.m_awvalid = !aw_done_q;
                bus.m_wvalid  = !w_done_q;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bus.m_bready = 1'b1;
                if (bus.m_bvalid) state_d = ST_RESP;
            end
            ST_RD_ADDR: begin
                bus.m_arvalid = 1'b1;
                if (bus.m_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                bus.m_rready = 1'b1;
                if (bus.m_rvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= bus.req_addr;
                wdata_q   <= bus.req_wdata;
                wstrb_q   <= bus.req_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if ((state_q == ST_WR_RESP) && bus.m_bvalid) begin
                resp_q  <= bus.m_bresp;
                rdata_q <= '0;
            end
            if ((state_q == ST_RD_DATA) && bus.m_rvalid) begin
                resp_q  <= bus.m_rresp;
                rdata_q <= bus.m_rdata;
            end
        end
    end

    assign bus.m_awaddr  = addr_q;
    assign bus.m_araddr  = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_resp  = resp_q;

    axil_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_main_a0 (clk_main_a0),
        .rst_n       (rst_n),
        .clr         (accept),
        .en          (is_axi_wait(state_q)),
        .timeout_err (timeout_err)
    );
endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomised and directed bench for axil_cmd_master against a cycle-offset transaction model.
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int TO = 16;

    logic clk_main_a0 = 1'b0;
    logic rst_main_n  = 1'b0;
    logic timeout_err;
    logic exp_to;
    int   n_chk  = 0;
    int   n_fail = 0;

    axil_cmd_master_if bus();

    axil_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_main_a0);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wstrb = '0;   bus.rsp_ready = 1'b0;
        bus.m_awready = 1'b0; bus.m_wready  = 1'b0; bus.m_bvalid  = 1'b0; bus.m_bresp = '0;
        bus.m_arready = 1'b0; bus.m_rvalid  = 1'b0; bus.m_rdata   = '0;   bus.m_rresp = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk_eq(tag, 32'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready}), 32'd0);
    endtask

    // Presents one command while idle; returns at the first cycle after acceptance.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
        bus.req_wdata = d;    bus.req_wstrb = s;
        step();
        bus.req_valid = 1'b0; bus.req_write = 1'($urandom); bus.req_addr = $urandom;
        bus.req_wdata = $urandom; bus.req_wstrb = 4'($urandom);
    endtask

    task automatic finish_rsp(input logic [1:0] er, input logic [31:0] ed, input int hold);
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            chk_eq("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk_eq("hold_rsp_resp", 32'(bus.rsp_resp), 32'(er));
            chk_eq("hold_rsp_rdata", bus.rsp_rdata, ed);
            chk_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk_quiet("hold_axi_quiet");
            step();
        end
        bus.rsp_ready = 1'b1;
        chk_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk_eq("rsp_resp", 32'(bus.rsp_resp), 32'(er));
        chk_eq("rsp_rdata", bus.rsp_rdata, ed);
        step();
        bus.rsp_ready = 1'b0;
        chk_eq("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
        chk_eq("rsp_done_req_ready", 32'(bus.req_ready), 32'd1);
        chk_eq("timeout_after", 32'(timeout_err), 32'(exp_to));
    endtask

    // k counts cycles from the first cycle after acceptance; the slave pulses each ready/valid once.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_d, input int w_d, input int b_d,
                            input logic [1:0] br, input int hold);
        int m, kb, kr;
        m  = (aw_d > w_d) ? aw_d : w_d;
        kb = m + 1 + b_d;
        kr = kb + 1;
        issue(1'b1, a, d, s);
        for (int k = 0; k <= kr; k++) begin
            bus.m_awready = (k == aw_d);
            bus.m_wready  = (k == w_d);
            bus.m_bvalid  = (k == kb);
            bus.m_bresp   = (k == kb) ? br : ~br;
            if (k >= TO) exp_to = 1'b1;
            chk_eq("wr_awvalid", 32'(bus.m_awvalid), 32'(k <= aw_d));
            chk_eq("wr_wvalid", 32'(bus.m_wvalid), 32'(k <= w_d));
            chk_eq("wr_bready", 32'(bus.m_bready), 32'((k > m) && (k <= kb)));
            chk_eq("wr_rsp_valid", 32'(bus.rsp_valid), 32'(k == kr));
            chk_eq("wr_no_read", 32'({bus.m_arvalid, bus.m_rready}), 32'd0);
            chk_eq("wr_timeout", 32'(timeout_err), 32'(exp_to));
            if (k <= aw_d) chk_eq("wr_awaddr", bus.m_awaddr, a);
            if (k <= w_d) begin
                chk_eq("wr_wdata", bus.m_wdata, d);
                chk_eq("wr_wstrb", 32'(bus.m_wstrb), 32'(s));
            end
            if (k < kr) step();
        end
        idle_inputs();
        finish_rsp(br, 32'd0, hold);
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_d, input int r_d,
                           input logic [31:0] rd, input logic [1:0] rr, input int hold);
        int kv, kr;
        kv = ar_d + 1 + r_d;
        kr = kv + 1;
        issue(1'b0, a, $urandom, 4'($urandom));
        for (int k = 0; k <= kr; k++) begin
            bus.m_arready = (k == ar_d);
            bus.m_rvalid  = (k == kv);
            bus.m_rdata   = (k == kv) ? rd : $urandom;
            bus.m_rresp   = (k == kv) ? rr : ~rr;
            if (k >= TO) exp_to = 1'b1;
            chk_eq("rd_arvalid", 32'(bus.m_arvalid), 32'(k <= ar_d));
            chk_eq("rd_rready", 32'(bus.m_rready), 32'((k > ar_d) && (k <= kv)));
            chk_eq("rd_rsp_valid", 32'(bus.rsp_valid), 32'(k == kr));
            chk_eq("rd_no_write", 32'({bus.m_awvalid, bus.m_wvalid, bus.m_bready}), 32'd0);
            chk_eq("rd_timeout", 32'(timeout_err), 32'(exp_to));
            if (k <= ar_d) chk_eq("rd_araddr", bus.m_araddr, a);
            if (k < kr) step();
        end
        idle_inputs();
        finish_rsp(rr, rd, hold);
    endtask

    initial begin
        idle_inputs();
        exp_to     = 1'b0;
        rst_main_n = 1'b0;
        repeat (3) step();
        chk_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk_quiet("rst_axi_quiet");
        chk_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk_eq("rst_rsp_resp", 32'(bus.rsp_resp), 32'd0);
        chk_eq("rst_awaddr", bus.m_awaddr, 32'd0);
        chk_eq("rst_timeout", 32'(timeout_err), 32'd0);
        rst_main_n = 1'b1;
        repeat (3) step();

        do_write(32'h0000_0500, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, RESP_OKAY, 0);
        do_write(32'h1000_0040, 32'hA5A5_0F0F, 4'h3, 5, 1, 2, RESP_OKAY, 1);
        do_read(32'h0000_0504, 0, 4, 32'h0000_1234, RESP_SLVERR, 0);
        do_write(32'h0000_0600, 32'h0BAD_F00D, 4'h9, 1, 0, 1, RESP_SLVERR, 10);

        chk_eq("timeout_pre", 32'(timeout_err), 32'd0);
        do_read(32'h0000_0508, 20, 1, 32'hCAFE_F00D, RESP_OKAY, 2);
        chk_eq("timeout_sticky", 32'(timeout_err), 32'd1);

        issue(1'b1, 32'h0000_0700, 32'h1111_2222, 4'hC);
        chk_eq("mid_awvalid_pre", 32'(bus.m_awvalid), 32'd1);
        step();
        step();
        rst_main_n = 1'b0;
        #1;
        chk_eq("mid_awvalid", 32'(bus.m_awvalid), 32'd0);
        chk_eq("mid_wvalid", 32'(bus.m_wvalid), 32'd0);
        chk_quiet("mid_axi_quiet");
        chk_eq("mid_awaddr", bus.m_awaddr, 32'd0);
        chk_eq("mid_wdata", bus.m_wdata, 32'd0);
        chk_eq("mid_timeout", 32'(timeout_err), 32'd0);
        chk_eq("mid_req_ready", 32'(bus.req_ready), 32'd1);
        exp_to = 1'b0;
        repeat (2) step();
        rst_main_n = 1'b1;
        repeat (3) step();
        chk_eq("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk_quiet("post_rst_quiet");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 9),
                         $urandom_range(0, 9), $urandom_range(0, 9), 2'($urandom),
                         $urandom_range(0, 3));
            else
                do_read($urandom, $urandom_range(0, 9), $urandom_range(0, 9), $urandom,
                        2'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
